// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: operation codes shared between the decode/execute stages and the
// multiply/divide unit, plus a small classification helper.
//   MDU_NONE..MDU_MTLO : 3-bit md_op encodings
//   is_long_op()       : true for the multi-cycle MULT/MULTU/DIV/DIVU group
package e_mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  // Operations that occupy the unit for a busy countdown.
  function automatic logic is_long_op(input logic [2:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding the architectural HI/LO.
// The result of a MULT*/DIV* is computed at the start edge into a pending
// pair and committed to hi/lo when the busy countdown expires.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   md_start, md_op     E-stage mult/div/mt request and its operation code
//   rs_val, rt_val      forwarded operands
//   d_is_md             D-stage instruction touches the unit
//   busy                long operation in flight (registered)
//   stall_req           decode stall request (combinational)
//   hi, lo              architectural HI/LO registers
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        pend_hi_r;
  logic [31:0]        pend_lo_r;
  logic               pend_we_r;   // cleared for divide-by-zero so hi/lo survive

  logic [63:0] rs_sx_s, rt_sx_s, rs_zx_s, rt_zx_s;
  logic [63:0] div_sx_s, div_zx_s;
  logic [63:0] prod_s_s, prod_u_s;
  logic [31:0] quot_s_s, rem_s_s, quot_u_s, rem_u_s;
  logic        rt_nz_s;

  // Operand extension and the behavioural arithmetic results.
  always_comb begin
    rs_sx_s  = {{32{rs_val[31]}}, rs_val};
    rt_sx_s  = {{32{rt_val[31]}}, rt_val};
    rs_zx_s  = {32'd0, rs_val};
    rt_zx_s  = {32'd0, rt_val};
    rt_nz_s  = (rt_val != 32'd0);
    // A zero divisor is replaced by 1 only to keep the datapath X-free; the
    // commit is suppressed through pend_we_r in that case.
    div_sx_s = rt_nz_s ? rt_sx_s : 64'd1;
    div_zx_s = rt_nz_s ? rt_zx_s : 64'd1;
    prod_s_s = $signed(rs_sx_s) * $signed(rt_sx_s);
    prod_u_s = rs_zx_s * rt_zx_s;
    // 64-bit signed division makes 0x80000000 / -1 come out as +2^31,
    // whose low word is 0x80000000 with remainder 0.
    quot_s_s = 32'($signed(rs_sx_s) / $signed(div_sx_s));
    rem_s_s  = 32'($signed(rs_sx_s) % $signed(div_sx_s));
    quot_u_s = 32'(rs_zx_s / div_zx_s);
    rem_u_s  = 32'(rs_zx_s % div_zx_s);
  end

  // Decode stall: in-flight operation, or one starting this very cycle.
  always_comb begin
    stall_req = d_is_md & (busy | (md_start & is_long_op(md_op)));
  end

  // Operation sequencing, busy countdown and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md_start) begin
            case (md_op)
              MDU_MULT: begin
                {pend_hi_r, pend_lo_r} <= prod_s_s;
                pend_we_r <= 1'b1;
                cnt_r     <= CNT_W'(MULT_CYCLES);
                busy      <= 1'b1;
                state_r   <= ST_BUSY;
              end
              MDU_MULTU: begin
                {pend_hi_r, pend_lo_r} <= prod_u_s;
                pend_we_r <= 1'b1;
                cnt_r     <= CNT_W'(MULT_CYCLES);
                busy      <= 1'b1;
                state_r   <= ST_BUSY;
              end
              MDU_DIV: begin
                pend_hi_r <= rem_s_s;
                pend_lo_r <= quot_s_s;
                pend_we_r <= rt_nz_s;
                cnt_r     <= CNT_W'(DIV_CYCLES);
                busy      <= 1'b1;
                state_r   <= ST_BUSY;
              end
              MDU_DIVU: begin
                pend_hi_r <= rem_u_s;
                pend_lo_r <= quot_u_s;
                pend_we_r <= rt_nz_s;
                cnt_r     <= CNT_W'(DIV_CYCLES);
                busy      <= 1'b1;
                state_r   <= ST_BUSY;
              end
              MDU_MTHI: hi <= rs_val;
              MDU_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          // Requests arriving here are ignored; the hazard unit prevents them.
          if (cnt_r == CNT_W'(1)) begin
            if (pend_we_r) begin
              hi <= pend_hi_r;
              lo <= pend_lo_r;
            end
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
